branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//  Resolution end of the branch prediction loop. Queues each fetch-side prediction {PC, predicted next PC} in program order.
//  Compares the oldest entry with the actual outcome from the resolve stage.
//  Generates flush/redirect on mismatch and issues BTB and 2-bit counter update writes back to the predictor.
//  Sits between the EX-stage branch condition/target logic and the IF-stage predictor.
// PARAMETERS
//  WORD_SIZE  16  PC/instruction width (`WORD_SIZE from opcodes.v)
//  DEPTH      4   in-flight prediction queue entries, power of 2, >=2
//  INDEX_W    8   BTB index width; tag width = WORD_SIZE-INDEX_W
// PORTS
//  clk            in   1          single clock, all state on posedge
//  reset          in   1          synchronous, active-high
//  pred_valid     in   1          fetch pushes one prediction
//  pred_PC        in   WORD_SIZE  PC of fetched instruction
//  pred_next_PC   in   WORD_SIZE  PC the predictor chose as next
//  res_valid      in   1          resolve stage retires oldest instruction
//  res_PC         in   WORD_SIZE  PC of resolving instruction
//  res_is_branch  in   1          opcode is BNE/BEQ/BGZ/BLZ
//  res_taken      in   1          branch condition result
//  res_target     in   WORD_SIZE  PC+Imm (always-taken address)
//  q_full         out  1          queue full; fetch must stall
//  flush          out  1          one-cycle pulse: squash IF/ID
//  redirect_PC    out  WORD_SIZE  correct next PC, valid with flush
//  upd_valid      out  1          one-cycle BTB/counter write strobe
//  upd_index      out  INDEX_W    res_PC[INDEX_W-1:0]
//  upd_tag        out  WORD_SIZE-INDEX_W  res_PC[WORD_SIZE-1:INDEX_W]
//  upd_target     out  WORD_SIZE  res_target
//  upd_taken      out  1          res_taken, drives the global counter
//  err_sticky     out  2          [0] underflow, [1] overflow; cleared only by reset
// BEHAVIOUR
//  Reset: queue empty, q_full=0, flush=0, redirect_PC=0, upd_*=0, err_sticky=0.
//  Actual next PC: act = (res_is_branch & res_taken) ? res_target : res_PC+1 (mod 2^WORD_SIZE).
//  On res_valid, pop the head entry {hPC, hNext}.
//  Mispredict is decided combinationally as (hPC != res_PC) | (hNext != act).
//  Latency 1: flush, redirect_PC=act, and upd_* are registered and visible the cycle after res_valid.
//  Each of flush and upd_valid is high for exactly one cycle per resolved event.
//  Update fires for every resolved branch, mispredicted or not. Non-branches never update.
//  Mispredict edge: the whole queue is cleared and the head/tail/count reset to 0. A same-cycle push is discarded (wrong path).
//  While flush=1: pushes are discarded, since fetch is being redirected. A res_valid in the flush cycle is ignored (ID/EX squashed).
//  Push and pop in the same cycle with no mispredict: count unchanged, legal even when full.
//  Push while full with no pop: dropped, err_sticky[1] set.
//  Pop while empty: hPC/hNext are treated as res_PC/res_PC+1, and err_sticky[0] is set.
//  Pointers wrap modulo DEPTH. q_full = (count==DEPTH), registered.
//  Reset mid-operation: everything returns to reset values on that edge. In-flight pulses are cancelled.
// CONFIGURATION
//  BR_STATS_EN defined: adds outputs stat_branches[15:0] and stat_mispred[15:0].
//   - stat_branches counts resolved branches; stat_mispred counts flushes.
//   - Both saturate at 16'hFFFF and are reset to 0.
//  BR_STATS_EN undefined: those ports and counters do not exist. Other behaviour is identical.
// STRUCTURE
//  Shared include bp_defs.vh holds:
//   - INDEX_W/TAG_W defines
//   - the 2-bit counter state encodings (SNT=00, WNT=01, WT=10, ST=11)
//   - the BTB invalid-target constant 16'hFFFF
//  Opcode defines come from opcodes.v.
//  One sub-module: bp_inflight_fifo, a parameterised FIFO with push/pop/clear, count, full/empty, and a head read port.
// TESTING
//  1. Reset, then push {0x0010,0x0011} and pop non-branch res_PC=0x0010 -> next cycle flush=0, upd_valid=0, queue empty.
//  2. Push {0x0020,0x0021}; pop BEQ res_PC=0x0020, taken, target=0x0030 -> flush=1, redirect_PC=0x0030.
//     Same cycle: upd_valid=1, index=0x20, tag=0x00, target=0x0030, taken=1. Queue count=0.
//  3. Push {0x0040,0x0045}; pop BNE res_PC=0x0040, taken, target=0x0045 -> flush=0, upd_valid=1, upd_taken=1.
//  4. Push 4 entries with no pop -> q_full=1. 5th push -> dropped, err_sticky=2'b10.
//     Then push+pop in the same cycle -> count stays 4.
//  5. Pop on empty with res_PC=0xFFFF non-branch -> act wraps to 0x0000, no flush, err_sticky[0]=1.
//  6. Mispredict with a simultaneous push, then res_valid during the flush cycle -> push dropped.
//     Second res_valid ignored; exactly one flush pulse.
//     With BR_STATS_EN: stat_mispred increments by 1.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver slice: default geometry,
// 2-bit predictor counter encodings, BTB invalid-target constant and the
// saturating increment used by the optional statistics counters.
package branch_resolver_pkg;

   localparam int BR_WORD_SIZE = 16;
   localparam int BR_DEPTH     = 4;
   localparam int BR_INDEX_W   = 8;
   localparam int BR_TAG_W     = BR_WORD_SIZE - BR_INDEX_W;

   // 2-bit saturating direction counter states
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_state_e;

   localparam logic [15:0] BTB_INVALID_TGT = 16'hFFFF;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/resolve/update bus of the branch resolver.
// master = pipeline side driving predictions and outcomes,
// slave  = the resolver. Optional statistics (BR_STATS_EN) ride on the bus.
interface branch_resolver_if #(
   parameter int WORD_SIZE = 16,
   parameter int INDEX_W   = 8
);
   logic                         pred_valid;
   logic [WORD_SIZE-1:0]         pred_PC;
   logic [WORD_SIZE-1:0]         pred_next_PC;
   logic                         res_valid;
   logic [WORD_SIZE-1:0]         res_PC;
   logic                         res_is_branch;
   logic                         res_taken;
   logic [WORD_SIZE-1:0]         res_target;
   logic                         q_full;
   logic                         flush;
   logic [WORD_SIZE-1:0]         redirect_PC;
   logic                         upd_valid;
   logic [INDEX_W-1:0]           upd_index;
   logic [WORD_SIZE-INDEX_W-1:0] upd_tag;
   logic [WORD_SIZE-1:0]         upd_target;
   logic                         upd_taken;
   logic [1:0]                   err_sticky;
`ifdef BR_STATS_EN
   logic [15:0]                  stat_branches;
   logic [15:0]                  stat_mispred;
`endif

   modport master (
`ifdef BR_STATS_EN
      input  stat_branches, stat_mispred,
`endif
      output pred_valid, pred_PC, pred_next_PC,
      output res_valid, res_PC, res_is_branch, res_taken, res_target,
      input  q_full, flush, redirect_PC,
      input  upd_valid, upd_index, upd_tag, upd_target, upd_taken,
      input  err_sticky
   );

   modport slave (
`ifdef BR_STATS_EN
      output stat_branches, stat_mispred,
`endif
      input  pred_valid, pred_PC, pred_next_PC,
      input  res_valid, res_PC, res_is_branch, res_taken, res_target,
      output q_full, flush, redirect_PC,
      output upd_valid, upd_index, upd_tag, upd_target, upd_taken,
      output err_sticky
   );
endinterface

// File: rtl/branch_resolver_fifo.sv
// bp_inflight_fifo: in-order queue of in-flight predictions.
// Push/pop/clear, occupancy count, full/empty flags and a head read port.
// Clear has priority over push/pop. A push while full is accepted only
// when a pop frees the slot in the same cycle.
module bp_inflight_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [W-1:0]               i_push_data,
   input  logic                       i_pop,
   input  logic                       i_clear,
   output logic [W-1:0]               o_head,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_full;

   logic             w_pop_ok;
   logic             w_push_ok;
   logic [CNT_W-1:0] w_count_nxt;

   // Accepted push/pop and next occupancy
   always_comb begin
      w_pop_ok    = i_pop & (r_count != CNT_W'(0));
      w_push_ok   = i_push & (~r_full | w_pop_ok);
      w_count_nxt = r_count;
      case ({w_push_ok, w_pop_ok})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Pointers, count and registered full flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= PTR_W'(0);
         r_tail  <= PTR_W'(0);
         r_count <= CNT_W'(0);
         r_full  <= 1'b0;
      end else if (i_clear) begin
         r_head  <= PTR_W'(0);
         r_tail  <= PTR_W'(0);
         r_count <= CNT_W'(0);
         r_full  <= 1'b0;
      end else begin
         if (w_pop_ok) begin
            r_head <= r_head + PTR_W'(1);
         end
         if (w_push_ok) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push_ok && !i_clear) begin
         r_mem[r_tail] <= i_push_data;
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;
   assign o_full  = r_full;
   assign o_empty = (r_count == CNT_W'(0));

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: compares the oldest queued prediction with the resolved
// outcome, raises a one-cycle flush/redirect on mismatch and emits BTB /
// direction-counter update strobes for every resolved branch.
// Optional macro BR_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int WORD_SIZE = BR_WORD_SIZE,
   parameter int DEPTH     = BR_DEPTH,
   parameter int INDEX_W   = BR_INDEX_W
) (
   input  logic              clk,
   input  logic              reset,
   branch_resolver_if.slave  bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int TAG_W = WORD_SIZE - INDEX_W;

   logic                   r_flush;
   logic [WORD_SIZE-1:0]   r_redirect;
   logic                   r_upd_valid;
   logic [INDEX_W-1:0]     r_upd_index;
   logic [TAG_W-1:0]       r_upd_tag;
   logic [WORD_SIZE-1:0]   r_upd_target;
   logic                   r_upd_taken;
   logic [1:0]             r_err;

   logic [2*WORD_SIZE-1:0] w_head;
   logic [CNT_W-1:0]       w_count;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_res_act;
   logic                   w_push_req;
   logic [WORD_SIZE-1:0]   w_h_pc;
   logic [WORD_SIZE-1:0]   w_h_next;
   logic [WORD_SIZE-1:0]   w_seq;
   logic [WORD_SIZE-1:0]   w_act;
   logic                   w_mis;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_ovf;
   logic                   w_unf;
   logic                   w_upd_fire;

   bp_inflight_fifo #(
      .W     (2*WORD_SIZE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data ({bus.pred_PC, bus.pred_next_PC}),
      .i_pop       (w_pop),
      .i_clear     (w_mis),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   // Resolve compare: actual next PC, head selection and mispredict decision
   always_comb begin
      // Anything arriving during the flush cycle belongs to the squashed path
      w_res_act  = bus.res_valid & ~r_flush;
      w_push_req = bus.pred_valid & ~r_flush;
      w_seq      = bus.res_PC + WORD_SIZE'(1);
      if (bus.res_is_branch && bus.res_taken) begin
         w_act = bus.res_target;
      end else begin
         w_act = w_seq;
      end
      // An empty queue resolves against the fall-through, so it cannot mispredict on its own
      if (w_empty) begin
         w_h_pc   = bus.res_PC;
         w_h_next = w_seq;
      end else begin
         w_h_pc   = w_head[2*WORD_SIZE-1:WORD_SIZE];
         w_h_next = w_head[WORD_SIZE-1:0];
      end
      w_mis      = w_res_act & ((w_h_pc != bus.res_PC) | (w_h_next != w_act));
      w_pop      = w_res_act & ~w_empty & ~w_mis;
      w_push     = w_push_req & ~w_mis;
      w_ovf      = w_push_req & ~w_mis & ~w_pop & (w_count == CNT_W'(DEPTH));
      w_unf      = w_res_act & w_empty;
      w_upd_fire = w_res_act & bus.res_is_branch;
   end

   // Registered flush/redirect, predictor update strobe and sticky errors
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flush      <= 1'b0;
         r_redirect   <= '0;
         r_upd_valid  <= 1'b0;
         r_upd_index  <= '0;
         r_upd_tag    <= '0;
         r_upd_target <= '0;
         r_upd_taken  <= 1'b0;
         r_err        <= 2'b00;
      end else begin
         r_flush     <= w_mis;
         r_upd_valid <= w_upd_fire;
         if (w_mis) begin
            r_redirect <= w_act;
         end
         if (w_upd_fire) begin
            r_upd_index  <= bus.res_PC[INDEX_W-1:0];
            r_upd_tag    <= bus.res_PC[WORD_SIZE-1:INDEX_W];
            r_upd_target <= bus.res_target;
            r_upd_taken  <= bus.res_taken;
         end
         r_err <= r_err | {w_ovf, w_unf};
      end
   end

   assign bus.q_full      = w_full;
   assign bus.flush       = r_flush;
   assign bus.redirect_PC = r_redirect;
   assign bus.upd_valid   = r_upd_valid;
   assign bus.upd_index   = r_upd_index;
   assign bus.upd_tag     = r_upd_tag;
   assign bus.upd_target  = r_upd_target;
   assign bus.upd_taken   = r_upd_taken;
   assign bus.err_sticky  = r_err;

`ifdef BR_STATS_EN
   logic [15:0] r_stat_br;
   logic [15:0] r_stat_mis;

   // Saturating counts of resolved branches and of flushes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_br  <= 16'd0;
         r_stat_mis <= 16'd0;
      end else begin
         if (w_upd_fire) begin
            r_stat_br <= sat_inc16(r_stat_br);
         end
         if (w_mis) begin
            r_stat_mis <= sat_inc16(r_stat_mis);
         end
      end
   end

   assign bus.stat_branches = r_stat_br;
   assign bus.stat_mispred  = r_stat_mis;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_branch_resolver;
   import branch_resolver_pkg::*;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int IW = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   branch_resolver_if #(.WORD_SIZE(W), .INDEX_W(IW)) bus ();

   branch_resolver #(.WORD_SIZE(W), .DEPTH(D), .INDEX_W(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] nxt;
   } pred_t;

   pred_t       mq[$];
   logic        m_flush;
   logic [15:0] m_redir;
   logic        m_upd;
   logic [7:0]  m_idx;
   logic [7:0]  m_tag;
   logic [15:0] m_tgt;
   logic        m_tk;
   logic [1:0]  m_err;
   logic [15:0] m_br;
   logic [15:0] m_mis;

   function automatic void model_reset();
      mq.delete();
      m_flush = 1'b0; m_redir = 16'h0; m_upd = 1'b0; m_idx = 8'h0; m_tag = 8'h0;
      m_tgt = 16'h0; m_tk = 1'b0; m_err = 2'b00; m_br = 16'h0; m_mis = 16'h0;
   endfunction

   function automatic void model_edge(input logic pv, input logic [15:0] ppc, input logic [15:0] pnext,
                                      input logic rv, input logic [15:0] rpc, input logic rbr,
                                      input logic rtk, input logic [15:0] rtgt);
      bit          res_eff;
      bit          push_eff;
      bit          mis;
      pred_t       h;
      pred_t       p;
      logic [15:0] act;
      res_eff  = rv && !m_flush;
      push_eff = pv && !m_flush;
      act = (rbr && rtk) ? rtgt : 16'(rpc + 16'd1);
      mis = 1'b0;
      if (res_eff) begin
         if (mq.size() == 0) begin
            h.pc  = rpc;
            h.nxt = 16'(rpc + 16'd1);
            m_err[0] = 1'b1;
         end else begin
            h = mq[0];
         end
         mis = (h.pc != rpc) || (h.nxt != act);
      end
      m_flush = mis;
      if (mis) begin
         m_redir = act;
         if (m_mis != 16'hFFFF) m_mis = m_mis + 16'd1;
      end
      m_upd = res_eff && rbr;
      if (m_upd) begin
         m_idx = rpc[7:0];
         m_tag = rpc[15:8];
         m_tgt = rtgt;
         m_tk  = rtk;
         if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
      end
      if (mis) begin
         mq.delete();
      end else begin
         if (res_eff && mq.size() > 0) void'(mq.pop_front());
         if (push_eff) begin
            if (mq.size() < D) begin
               p.pc  = ppc;
               p.nxt = pnext;
               mq.push_back(p);
            end else begin
               m_err[1] = 1'b1;
            end
         end
      end
   endfunction

   task automatic check_all();
      check_val("flush",  32'(bus.flush),      32'(m_flush));
      check_val("q_full", 32'(bus.q_full),     32'(mq.size() == D));
      check_val("err",    32'(bus.err_sticky), 32'(m_err));
      check_val("upd_v",  32'(bus.upd_valid),  32'(m_upd));
      if (m_flush) check_val("redir", 32'(bus.redirect_PC), 32'(m_redir));
      if (m_upd) begin
         check_val("upd_idx", 32'(bus.upd_index),  32'(m_idx));
         check_val("upd_tag", 32'(bus.upd_tag),    32'(m_tag));
         check_val("upd_tgt", 32'(bus.upd_target), 32'(m_tgt));
         check_val("upd_tk",  32'(bus.upd_taken),  32'(m_tk));
      end
`ifdef BR_STATS_EN
      check_val("st_br",  32'(bus.stat_branches), 32'(m_br));
      check_val("st_mis", 32'(bus.stat_mispred),  32'(m_mis));
`endif
   endtask

   // One clock: drive, let the edge happen, advance model, check
   task automatic cyc(input logic pv, input logic [15:0] ppc, input logic [15:0] pnext,
                      input logic rv, input logic [15:0] rpc, input logic rbr,
                      input logic rtk, input logic [15:0] rtgt);
      bus.pred_valid    = pv;
      bus.pred_PC       = ppc;
      bus.pred_next_PC  = pnext;
      bus.res_valid     = rv;
      bus.res_PC        = rpc;
      bus.res_is_branch = rbr;
      bus.res_taken     = rtk;
      bus.res_target    = rtgt;
      @(posedge clk);
      if (reset) model_reset();
      else model_edge(pv, ppc, pnext, rv, rpc, rbr, rtk, rtgt);
      #1;
      check_all();
   endtask

   task automatic idle();
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic check_reset_state();
      check_val("rst_flush", 32'(bus.flush),       32'h0);
      check_val("rst_full",  32'(bus.q_full),      32'h0);
      check_val("rst_redir", 32'(bus.redirect_PC), 32'h0);
      check_val("rst_updv",  32'(bus.upd_valid),   32'h0);
      check_val("rst_updi",  32'(bus.upd_index),   32'h0);
      check_val("rst_updg",  32'(bus.upd_tag),     32'h0);
      check_val("rst_updt",  32'(bus.upd_target),  32'h0);
      check_val("rst_updk",  32'(bus.upd_taken),   32'h0);
      check_val("rst_err",   32'(bus.err_sticky),  32'h0);
   endtask

   logic        r_pv;
   logic [15:0] r_ppc;
   logic [15:0] r_pnext;
   logic        r_rv;
   logic [15:0] r_rpc;
   logic        r_rbr;
   logic        r_rtk;
   logic [15:0] r_rtgt;
   logic [15:0] fpc;

   initial begin
      model_reset();
      reset = 1'b1;
      idle();
      idle();
      check_reset_state();
      reset = 1'b0;

      // 1: non-branch resolves matching prediction
      cyc(1'b1, 16'h0010, 16'h0011, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0);
      check_val("t1_flush", 32'(bus.flush),     32'h0);
      check_val("t1_updv",  32'(bus.upd_valid), 32'h0);

      // 2: BEQ taken mispredicted
      cyc(1'b1, 16'h0020, 16'h0021, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0030);
      check_val("t2_flush", 32'(bus.flush),       32'h1);
      check_val("t2_redir", 32'(bus.redirect_PC), 32'h0030);
      check_val("t2_updv",  32'(bus.upd_valid),   32'h1);
      check_val("t2_idx",   32'(bus.upd_index),   32'h20);
      check_val("t2_tag",   32'(bus.upd_tag),     32'h00);
      check_val("t2_tgt",   32'(bus.upd_target),  32'h0030);
      check_val("t2_tk",    32'(bus.upd_taken),   32'h1);
      idle();
      check_val("t2_pulse", 32'(bus.flush), 32'h0);

      // 3: BNE taken, correctly predicted
      cyc(1'b1, 16'h0040, 16'h0045, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0045);
      check_val("t3_flush", 32'(bus.flush),     32'h0);
      check_val("t3_updv",  32'(bus.upd_valid), 32'h1);
      check_val("t3_tk",    32'(bus.upd_taken), 32'h1);

      // 4: fill, overflow, push+pop while full
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 16'(16'h0100 + i), 16'(16'h0101 + i), 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      end
      check_val("t4_full", 32'(bus.q_full), 32'h1);
      cyc(1'b1, 16'h0104, 16'h0105, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      check_val("t4_ovf", 32'(bus.err_sticky), 32'h2);
      cyc(1'b1, 16'h0104, 16'h0105, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0);
      check_val("t4_pp_full",  32'(bus.q_full), 32'h1);
      check_val("t4_pp_flush", 32'(bus.flush),  32'h0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'(16'h0101 + i), 1'b0, 1'b0, 16'h0);
         check_val("t4_drain", 32'(bus.flush), 32'h0);
      end

      // 5: pop on empty with wrap of the fall-through PC
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0);
      check_val("t5_flush", 32'(bus.flush),      32'h0);
      check_val("t5_err",   32'(bus.err_sticky), 32'h3);

      // 6: mispredict with same-cycle push, then res_valid in flush cycle
      cyc(1'b1, 16'h0200, 16'h0201, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      cyc(1'b1, 16'h0300, 16'h0301, 1'b1, 16'h0200, 1'b1, 1'b1, 16'h0250);
      check_val("t6_flush", 32'(bus.flush),       32'h1);
      check_val("t6_redir", 32'(bus.redirect_PC), 32'h0250);
      cyc(1'b1, 16'h0400, 16'h0401, 1'b1, 16'h0300, 1'b1, 1'b0, 16'h0);
      check_val("t6_one",   32'(bus.flush),     32'h0);
      check_val("t6_ign",   32'(bus.upd_valid), 32'h0);
      // queue must be empty now: an arbitrary PC resolves without flush
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0777, 1'b0, 1'b0, 16'h0);
      check_val("t6_empty", 32'(bus.flush), 32'h0);

      // reset in the middle of a mispredict
      cyc(1'b1, 16'h0500, 16'h0501, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      reset = 1'b1;
      cyc(1'b1, 16'h0600, 16'h0601, 1'b1, 16'h0500, 1'b1, 1'b1, 16'h0900);
      check_reset_state();
      reset = 1'b0;

      // randomized traffic against the model
      fpc = 16'h1000;
      for (int i = 0; i < 800; i++) begin
         r_pv    = 1'($urandom_range(0, 1));
         r_ppc   = fpc;
         r_pnext = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(fpc + 16'd1);
         fpc     = 16'(fpc + 16'd1);
         r_rv    = ($urandom_range(0, 2) != 0);
         r_rbr   = 1'($urandom_range(0, 1));
         r_rtk   = 1'($urandom_range(0, 1));
         if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
            r_rpc  = mq[0].pc;
            r_rtgt = ($urandom_range(0, 1) == 1) ? mq[0].nxt : 16'($urandom);
         end else begin
            r_rpc  = 16'($urandom);
            r_rtgt = 16'($urandom);
         end
         if (i == 400) reset = 1'b1;
         cyc(r_pv, r_ppc, r_pnext, r_rv, r_rpc, r_rbr, r_rtk, r_rtgt);
         reset = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
